// File: rtl/chunked_subtractor.sv
// Multi-cycle subtractor: D = A - B - borrow_in, one CHUNK-bit slice per clock,
// LSB slice first, each slice computed as A + ~B + ~borrow on a small CLA.

module cla #(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0] i_a,
  input  logic [BITS-1:0] i_b,
  input  logic            i_c,
  output logic [BITS-1:0] o_s,
  output logic            o_c
);
  logic [BITS-1:0] w_p;
  logic [BITS-1:0] w_g;
  logic [BITS:0]   w_c;
  logic            v_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  // Each carry is expanded independently from i_c so synthesis sees a flat lookahead term.
  always_comb begin
    w_c    = '0;
    w_c[0] = i_c;
    v_c    = 1'b0;
    for (int i = 0; i < BITS; i++) begin
      v_c = i_c;
      for (int j = 0; j <= i; j++) begin
        v_c = w_g[j] | (w_p[j] & v_c);
      end
      w_c[i+1] = v_c;
    end
  end

  assign o_s = w_p ^ w_c[BITS-1:0];
  assign o_c = w_c[BITS];
endmodule

// state  | meaning
// IDLE   | ready for operands
// RUN    | one slice per edge, borrow held in r_bw
// DONE   | result presented until downstream accepts
module chunked_subtractor #(
  parameter int BITS  = 32,
  parameter int CHUNK = 8
) (
  input  logic            i_clk_in,
  input  logic            i_rst_in,
  input  logic            i_valid_in,
  output logic            o_ready_out,
  input  logic [BITS-1:0] i_a_in,
  input  logic [BITS-1:0] i_b_in,
  input  logic            i_bw_in,
  output logic            o_valid_out,
  input  logic            i_ready_in,
  output logic [BITS-1:0] o_d_out,
  output logic            o_bw_out,
  output logic            o_ovf_out
);
  localparam int NCHUNK = BITS / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if ((BITS % CHUNK) != 0) begin : g_bad_chunk
      $error("chunked_subtractor: BITS must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [BITS-1:0] r_a;
  logic [BITS-1:0] r_b;
  logic            r_bw;
  logic            r_a_msb;
  logic            r_b_msb;
  logic [KW-1:0]   r_k;
  logic [BITS-1:0] r_res;
  logic [BITS-1:0] r_d;
  logic            r_bw_out;
  logic            r_ovf;

  logic [CHUNK-1:0] w_sum;
  logic             w_cout;
  logic [BITS-1:0]  w_sum_top;
  logic [BITS-1:0]  w_res_next;
  logic             w_last;
  logic             w_accept;

  // Operands shift down so the active slice is always the low CHUNK bits.
  cla #(.BITS(CHUNK)) u_cla (
    .i_a (r_a[CHUNK-1:0]),
    .i_b (~r_b[CHUNK-1:0]),
    .i_c (~r_bw),
    .o_s (w_sum),
    .o_c (w_cout)
  );

  // Result fills from the top; after NCHUNK slices the first one lands at bit 0.
  assign w_sum_top  = BITS'(w_sum) << (BITS - CHUNK);
  assign w_res_next = (r_res >> CHUNK) | w_sum_top;
  assign w_last     = (r_k == KW'(NCHUNK - 1));
  assign w_accept   = i_valid_in & o_ready_out;

  always_ff @(posedge i_clk_in) begin
    if (i_rst_in) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)   w_state_next = S_RUN;
      S_RUN:   if (w_last)     w_state_next = S_DONE;
      S_DONE:  if (i_ready_in) w_state_next = S_IDLE;
      default:                 w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready_out = (r_state == S_IDLE) & ~i_rst_in;
    o_valid_out = (r_state == S_DONE);
  end

  always_ff @(posedge i_clk_in) begin
    if (i_rst_in) begin
      r_a      <= '0;
      r_b      <= '0;
      r_bw     <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_k      <= '0;
      r_res    <= '0;
      r_d      <= '0;
      r_bw_out <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= i_a_in;
            r_b     <= i_b_in;
            r_bw    <= i_bw_in;
            r_a_msb <= i_a_in[BITS-1];
            r_b_msb <= i_b_in[BITS-1];
            r_k     <= '0;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> CHUNK;
          r_b   <= r_b >> CHUNK;
          r_bw  <= ~w_cout;
          r_res <= w_res_next;
          r_k   <= r_k + KW'(1);
          if (w_last) begin
            r_d      <= w_res_next;
            r_bw_out <= ~w_cout;
            r_ovf    <= (r_a_msb != r_b_msb) & (w_sum[CHUNK-1] != r_a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_d_out   = r_d;
  assign o_bw_out  = r_bw_out;
  assign o_ovf_out = r_ovf;
endmodule

// File: tb/tb_chunked_subtractor.sv
// Directed bench for chunked_subtractor: default 32/8 instance plus a
// single-slice 8/8 instance to cover NCHUNK=1.

module tb_chunked_subtractor;
   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in, ready_out, bw_in, valid_out, ready_in, bw_out, ovf_out;
   logic [31:0] a_in, b_in, d_out;
   logic        v8_in, r8_out, bw8_in, v8_out, r8_in, bw8_out, ovf8_out;
   logic [7:0]  a8_in, b8_in, d8_out;
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc;

   always #5 clk = ~clk;

   chunked_subtractor #(.BITS(32), .CHUNK(8)) u_dut (
      .i_clk_in(clk), .i_rst_in(rst), .i_valid_in(valid_in), .o_ready_out(ready_out),
      .i_a_in(a_in), .i_b_in(b_in), .i_bw_in(bw_in), .o_valid_out(valid_out),
      .i_ready_in(ready_in), .o_d_out(d_out), .o_bw_out(bw_out), .o_ovf_out(ovf_out)
   );

   chunked_subtractor #(.BITS(8), .CHUNK(8)) u_dut8 (
      .i_clk_in(clk), .i_rst_in(rst), .i_valid_in(v8_in), .o_ready_out(r8_out),
      .i_a_in(a8_in), .i_b_in(b8_in), .i_bw_in(bw8_in), .o_valid_out(v8_out),
      .i_ready_in(r8_in), .o_d_out(d8_out), .o_bw_out(bw8_out), .o_ovf_out(ovf8_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic bw,
                        input logic [31:0] ed, input logic ebw, input logic eovf,
                        input string tag);
      a_in = a; b_in = b; bw_in = bw; valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      check({tag, "_busy_ready"}, 32'(ready_out), 32'h0);
      cyc = 0;
      while (!valid_out && cyc < 20) begin
         tick();
         cyc++;
      end
      check({tag, "_latency"}, 32'(cyc), 32'd4);
      check({tag, "_d"}, d_out, ed);
      check({tag, "_bw"}, 32'(bw_out), 32'(ebw));
      check({tag, "_ovf"}, 32'(ovf_out), 32'(eovf));
      tick();
      check({tag, "_valid_drop"}, 32'(valid_out), 32'h0);
      check({tag, "_ready_back"}, 32'(ready_out), 32'h1);
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bw,
                       input logic [7:0] ed, input logic ebw, input logic eovf,
                       input string tag);
      a8_in = a; b8_in = b; bw8_in = bw; v8_in = 1'b1;
      tick();
      v8_in = 1'b0;
      cyc = 0;
      while (!v8_out && cyc < 20) begin
         tick();
         cyc++;
      end
      check({tag, "_latency"}, 32'(cyc), 32'd1);
      check({tag, "_d"}, 32'(d8_out), 32'(ed));
      check({tag, "_bw"}, 32'(bw8_out), 32'(ebw));
      check({tag, "_ovf"}, 32'(ovf8_out), 32'(eovf));
      tick();
      check({tag, "_ready_back"}, 32'(r8_out), 32'h1);
   endtask

   initial begin
      rst = 1'b1; ready_in = 1'b1; valid_in = 1'b0; a_in = '0; b_in = '0; bw_in = 1'b0;
      r8_in = 1'b1; v8_in = 1'b0; a8_in = '0; b8_in = '0; bw8_in = 1'b0;
      tick();
      tick();
      check("rst_ready", 32'(ready_out), 32'h0);
      check("rst_valid", 32'(valid_out), 32'h0);
      check("rst_d", d_out, 32'h0);
      check("rst_bw", 32'(bw_out), 32'h0);
      rst = 1'b0;
      #1;
      check("idle_ready", 32'(ready_out), 32'h1);
      tick();

      run32(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, "basic");
      run32(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, "ripple");
      run32(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, "ovf_neg");
      run32(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, "ovf_pos");
      run32(32'h0000_0100, 32'h0000_00FF, 1'b1, 32'h0000_0000, 1'b0, 1'b0, "bwin");

      // Backpressure with a competing request held on the inputs the whole time
      ready_in = 1'b0;
      a_in = 32'h1234_5678; b_in = 32'h1111_1111; bw_in = 1'b0; valid_in = 1'b1;
      tick();
      a_in = 32'hDEAD_0000; bw_in = 1'b1;
      check("bp_busy_ready", 32'(ready_out), 32'h0);
      cyc = 0;
      while (!valid_out && cyc < 20) begin
         tick();
         cyc++;
      end
      check("bp_latency", 32'(cyc), 32'd4);
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_valid", 32'(valid_out), 32'h1);
         check("bp_hold_d", d_out, 32'h0123_4567);
         check("bp_hold_bw", 32'(bw_out), 32'h0);
         check("bp_hold_ready", 32'(ready_out), 32'h0);
         tick();
      end
      valid_in = 1'b0;
      ready_in = 1'b1;
      tick();
      check("bp_release_valid", 32'(valid_out), 32'h0);
      check("bp_release_ready", 32'(ready_out), 32'h1);
      check("bp_release_d_kept", d_out, 32'h0123_4567);

      // Reset after two slices of an in-flight op
      a_in = 32'h0000_FFFF; b_in = 32'h0000_0001; bw_in = 1'b0; valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("abort_valid", 32'(valid_out), 32'h0);
      check("abort_d", d_out, 32'h0);
      check("abort_ready", 32'(ready_out), 32'h1);
      tick();
      run32(32'd10, 32'd4, 1'b0, 32'd6, 1'b0, 1'b0, "post_abort");

      // Single-slice instance
      run8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "n1_ripple");
      run8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "n1_ovf");
      run8(8'h10, 8'h05, 1'b1, 8'h0A, 1'b0, 1'b0, "n1_bwin");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/chunked_subtractor.md
Name: chunked_subtractor

Overview:
Multi-cycle unsigned/two's-complement subtractor that computes D = A − B − borrow_in. It processes CHUNK bits per clock, least-significant slice first, and carries the borrow between slices in a register. It is the subtract-side companion to the team's parametric carry-lookahead adder: each slice is computed as A_slice + ~B_slice + ~borrow on a cla instance with BITS=CHUNK. It sits in the filter datapath where a wide subtraction is needed but a full-width lookahead tree is too costly in area, and it uses a valid/ready handshake on both sides.

Parameters:
BITS, 32, operand and result width.
CHUNK, 8, slice width processed per cycle. BITS % CHUNK must be 0, otherwise elaboration fails.
NCHUNK (derived, localparam), BITS/CHUNK, number of slice cycles.

Ports:
_clk_in  input  1  clock; all state changes on its rising edge.
_rst_in  input  1  synchronous, active-high reset.
_valid_in  input  1  operands valid.
_ready_out  output  1  block can accept operands.
_a_in  input  BITS  minuend.
_b_in  input  BITS  subtrahend.
_bw_in  input  1  borrow in.
_valid_out  output  1  result valid.
_ready_in  input  1  downstream accepts result.
_d_out  output  BITS  difference, modulo 2^BITS.
_bw_out  output  1  borrow out; 1 iff A < B + bw_in (unsigned).
_ovf_out  output  1  signed overflow.

Behaviour:
- Reset (_rst_in high at an edge):
  - State goes to IDLE.
  - _valid_out=0, _d_out=0, _bw_out=0, _ovf_out=0.
  - Slice counter cleared; operand registers cleared.
  - _ready_out=0 while _rst_in is high.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - _ready_out=1.
  - Accept occurs at an edge where _valid_in & _ready_out. At that edge the block latches A, B and borrow=_bw_in, clears counter k to 0, and goes to RUN.
  - Inputs are ignored whenever _ready_out=0.
- RUN:
  - _ready_out=0 and _valid_out=0.
  - At each edge, slice k = A[k*CHUNK +: CHUNK] + ~B_slice + ~borrow (CHUNK-bit cla).
  - The sum is written into result[k*CHUNK +: CHUNK], and borrow is updated to ~carry_out. k then increments.
  - After the edge that computes slice NCHUNK−1, go to DONE.
- DONE:
  - _valid_out=1.
  - _d_out = result, _bw_out = final borrow.
  - _ovf_out = (A[BITS−1] != B[BITS−1]) & (D[BITS−1] != A[BITS−1]).
  - All outputs stay stable until _valid_out & _ready_in at an edge, which moves the state to IDLE.
  - After that edge _valid_out=0, and _d_out/_bw_out/_ovf_out keep their last value.
- Latency: _valid_out rises exactly NCHUNK cycles after the accepting edge. For the defaults that is 4.
- Throughput: no overlap between operations. The minimum spacing between accepts is NCHUNK+2 cycles with _ready_in held high.
- CHUNK==BITS gives NCHUNK=1: a single RUN cycle, and the same rules apply.
- Borrow ripples correctly across every slice boundary; a borrow generated in slice 0 can propagate through to the final _bw_out.
- Reset mid-RUN or mid-DONE aborts the operation. The next cycle shows the reset values, and no partial result is ever presented.
- Changes on _a_in/_b_in/_bw_in after acceptance have no effect on the result.

Test Plan:
1. BITS=32, CHUNK=8. Accept a=0x00000005, b=0x00000003, bw=0 → 4 cycles later _valid_out=1, d=0x00000002, bw_out=0, ovf=0.
2. a=0x00000000, b=0x00000001, bw=0 → d=0xFFFFFFFF, bw_out=1, ovf=0; borrow ripples through all 4 slices.
3. Signed overflow, two cases:
   - a=0x80000000, b=0x00000001 → d=0x7FFFFFFF, bw_out=0, ovf=1.
   - a=0x7FFFFFFF, b=0xFFFFFFFF → d=0x80000000, bw_out=1, ovf=1.
4. Borrow-in: a=0x00000100, b=0x000000FF, bw=1 → d=0x00000000, bw_out=0, ovf=0.
5. Backpressure and busy handling:
   - Hold _ready_in=0 for 5 cycles in DONE → _valid_out and all outputs held constant.
   - While busy, drive _valid_in=1 with a=0xDEAD0000 → _ready_out=0 and the in-flight result is unchanged.
   - Raise _ready_in → next cycle _ready_out=1.
6. Assert _rst_in for 1 cycle after 2 RUN slices → next cycle _valid_out=0, d=0, _ready_out=1. A following op a=10, b=4 returns d=6 after 4 cycles.
